// File: rtl/pc_gen_unit.sv
// Fetch-address generator at the head of IF: imem handshake, trap/redirect priority,
// stall-time redirect buffering, misaligned-target rejection, halt control and a fetch counter.
module pc_gen_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                IALIGN       = 32,
  parameter int                CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             pc_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  input  logic             halt_req,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Bits that must be zero in a legal instruction address.
  localparam logic [XLEN-1:0] ALIGN_BITS = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

  state_t          state;
  state_t          state_next;
  logic            pend_valid;
  logic            pend_valid_next;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] pend_target_next;
  logic [XLEN-1:0] pc_next;
  logic            misalign_err_next;
  logic [XLEN-1:0] misalign_addr_next;
  logic            accept;
  logic            redirect_misaligned;

  assign accept              = pc_valid & pc_ready;
  assign redirect_misaligned = |(redirect_target & ALIGN_BITS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (halt_req) state_next = HALT;
      HALT:    if (!halt_req) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_valid = (state == RUN);
  end

  // Next-pc selection; BOOT performs no pc update, only the transition into RUN.
  always_comb begin
    pc_next            = pc;
    pend_valid_next    = pend_valid;
    pend_target_next   = pend_target;
    misalign_err_next  = 1'b0;
    misalign_addr_next = misalign_addr;
    if (state != BOOT) begin
      if (trap_valid) begin
        pc_next         = trap_target & ~ALIGN_BITS;
        pend_valid_next = 1'b0;
      end else if (redirect_valid) begin
        if (redirect_misaligned) begin
          misalign_err_next  = 1'b1;
          misalign_addr_next = redirect_target;
        end else if (pc_write) begin
          pc_next         = redirect_target;
          pend_valid_next = 1'b0;
        end else begin
          pend_target_next = redirect_target;
          pend_valid_next  = 1'b1;
        end
      end else if (pend_valid && pc_write) begin
        pc_next         = pend_target;
        pend_valid_next = 1'b0;
      end else if (accept && pc_write && state == RUN) begin
        pc_next = pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_VECTOR;
      pend_valid    <= 1'b0;
      pend_target   <= '0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
      fetch_count   <= '0;
    end else begin
      pc            <= pc_next;
      pend_valid    <= pend_valid_next;
      pend_target   <= pend_target_next;
      misalign_err  <= misalign_err_next;
      misalign_addr <= misalign_addr_next;
      if (accept) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: a default instance (IALIGN=32) and a second one with
// IALIGN=16 and a 4-bit counter share the same stimulus so alignment and wrap can be compared.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        pc_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_req;

  logic [31:0] pc;
  logic        pc_valid;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic [31:0] fetch_count;

  logic [31:0] pc16;
  logic        pc_valid16;
  logic        misalign_err16;
  logic [31:0] misalign_addr16;
  logic [3:0]  fetch_count16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_ready(pc_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_target(trap_target), .halt_req(halt_req),
    .pc(pc), .pc_valid(pc_valid), .misalign_err(misalign_err),
    .misalign_addr(misalign_addr), .fetch_count(fetch_count)
  );

  pc_gen_unit #(.IALIGN(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_ready(pc_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_target(trap_target), .halt_req(halt_req),
    .pc(pc16), .pc_valid(pc_valid16), .misalign_err(misalign_err16),
    .misalign_addr(misalign_addr16), .fetch_count(fetch_count16)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge, then new inputs are applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    pc_write        = 1'b1;
    pc_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_valid      = 1'b0;
    trap_target     = '0;
    halt_req        = 1'b0;

    #3;
    check("reset_pc", pc, 32'h0);
    check("reset_valid", {31'b0, pc_valid}, 32'h0);
    check("reset_err", {31'b0, misalign_err}, 32'h0);
    check("reset_maddr", misalign_addr, 32'h0);
    check("reset_count", fetch_count, 32'h0);

    tick();
    tick();
    rst = 1'b1;
    check("boot_valid", {31'b0, pc_valid}, 32'h0);

    tick();
    check("run_pc0", pc, 32'h0);
    check("run_valid", {31'b0, pc_valid}, 32'h1);
    check("run_count0", fetch_count, 32'd0);
    tick();
    check("run_pc4", pc, 32'h4);
    check("run_count1", fetch_count, 32'd1);
    tick();
    check("run_pc8", pc, 32'h8);
    check("run_count2", fetch_count, 32'd2);
    for (int i = 0; i < 6; i++) tick();
    check("run_pc20", pc, 32'h20);
    check("run_count8", fetch_count, 32'd8);

    pc_write        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();
    check("stall_hold1", pc, 32'h20);
    check("stall_count", fetch_count, 32'd9);
    redirect_valid = 1'b0;
    tick();
    tick();
    check("stall_hold3", pc, 32'h20);
    pc_write = 1'b1;
    tick();
    check("pend_apply", pc, 32'h100);
    tick();
    check("pend_cleared", pc, 32'h104);
    check("pend_count", fetch_count, 32'd13);

    pc_write        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    check("pend2_hold", pc, 32'h104);
    trap_valid      = 1'b1;
    trap_target     = 32'h203;
    redirect_target = 32'h400;
    tick();
    check("trap_pc", pc, 32'h200);
    check("trap_pc16", pc16, 32'h202);
    check("trap_count", fetch_count, 32'd15);
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    pc_write       = 1'b1;
    tick();
    check("trap_drop_pend", pc, 32'h204);
    check("trap_drop_pend16", pc16, 32'h206);
    check("count16_wrap", {28'b0, fetch_count16}, 32'h0);

    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    tick();
    check("mis_pc_hold", pc, 32'h204);
    check("mis_err", {31'b0, misalign_err}, 32'h1);
    check("mis_addr", misalign_addr, 32'h102);
    check("mis16_pc", pc16, 32'h102);
    check("mis16_err", {31'b0, misalign_err16}, 32'h0);
    redirect_valid = 1'b0;
    tick();
    check("mis_err_drop", {31'b0, misalign_err}, 32'h0);
    check("mis_addr_hold", misalign_addr, 32'h102);
    check("mis_pc_next", pc, 32'h208);

    trap_valid  = 1'b1;
    trap_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_top", pc, 32'hFFFF_FFFC);
    trap_valid = 1'b0;
    tick();
    check("wrap_zero", pc, 32'h0);
    check("wrap_count", fetch_count, 32'd20);

    halt_req = 1'b1;
    tick();
    check("halt_valid", {31'b0, pc_valid}, 32'h0);
    check("halt_pc", pc, 32'h4);
    tick();
    check("halt_frozen", pc, 32'h4);
    check("halt_count", fetch_count, 32'd21);

    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_pc", pc, 32'h0);
    check("rst_mid_valid", {31'b0, pc_valid}, 32'h0);
    check("rst_mid_count", fetch_count, 32'h0);
    check("rst_mid_maddr", misalign_addr, 32'h0);
    halt_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
